// File: rtl/unified_mem_arbiter_if.sv
// Handshake bundle between the MIPS core's fetch and data ports, the arbiter,
// and the single-ported unified memory.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Core and memory side: issues requests, returns memory read data.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch and data ports, with a programmable number of access cycles.
module unified_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    unified_mem_arbiter_if.slave   bus,
    output logic                   grant_d,
    output logic                   busy
);
    localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              grant_q;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              any_req;
    logic              pick_d;
    logic              last_beat;

    // grant_d and last_grant always hold the same value, so one register serves both.
    assign last_grant = grant_q;

    always_comb begin
        any_req    = bus.if_req | bus.d_req;
        pick_d     = bus.d_req & (~bus.if_req | ~last_grant);
        last_beat  = (cnt == CNT_LAST);
        next_state = state;
        unique case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  if (last_beat) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        bus.mem_en    = (state == ACCESS);
        bus.mem_we    = (state == ACCESS) & we_q;
        bus.if_ready  = (state == DONE) & ~grant_q;
        bus.d_ready   = (state == DONE) & grant_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;
        grant_d       = grant_q;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= pick_d;
                        we_q    <= pick_d & bus.d_we;
                        addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                        wdata_q <= bus.d_wdata;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_beat) begin
                        if (!grant_q)
                            if_rdata_q <= bus.mem_rdata;
                        else if (!we_q)
                            d_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: one arbiter with WAIT_CYCLES=1 and one with WAIT_CYCLES=3,
// each backed by a small word-addressed memory.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic init;
    logic grant_d1, busy1, grant_d3, busy3;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    unified_mem_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .grant_d(grant_d1), .busy(busy1));
    unified_mem_arbiter #(.WAIT_CYCLES(3), .ADDR_W(32), .DATA_W(32)) u3 (
        .clk(clk), .reset(reset), .bus(b3), .grant_d(grant_d3), .busy(busy3));

    always #5 clk = ~clk;

    assign b1.mem_rdata = mem1[b1.mem_addr[9:2]];
    assign b3.mem_rdata = mem3[b3.mem_addr[9:2]];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= '0;
                mem3[i] <= '0;
            end
            mem1[1]  <= 32'h2008_0005;
            mem1[2]  <= 32'h8C09_0054;
            mem1[21] <= 32'h1111_2222;
            mem3[2]  <= 32'h3C01_DEAD;
            mem3[4]  <= 32'h0000_ABCD;
        end else begin
            if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
            if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_reqs();
        b1.if_req = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b3.if_req = 1'b0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    endtask

    task automatic do_reset();
        drop_reqs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        init  = 1'b1;
        drop_reqs();
        b1.if_addr = '0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.if_addr = '0; b3.d_addr = '0; b3.d_wdata = '0;
        tick();
        init = 1'b0;

        // Reset held two cycles with requests active
        b1.if_req = 1'b1; b1.d_req = 1'b1; b1.if_addr = 32'h8; b1.d_addr = 32'h54;
        b1.d_wdata = 32'h55;
        b3.if_req = 1'b1; b3.d_req = 1'b1;
        tick();
        tick();
        chk("rst_mem_en",    b1.mem_en,    0);
        chk("rst_mem_we",    b1.mem_we,    0);
        chk("rst_if_ready",  b1.if_ready,  0);
        chk("rst_d_ready",   b1.d_ready,   0);
        chk("rst_busy",      busy1,        0);
        chk("rst_grant_d",   grant_d1,     0);
        chk("rst_mem_addr",  b1.mem_addr,  0);
        chk("rst_mem_wdata", b1.mem_wdata, 0);
        chk("rst_if_rdata",  b1.if_rdata,  0);
        chk("rst_d_rdata",   b1.d_rdata,   0);
        chk("rst_busy3",     busy3,        0);
        reset = 1'b0;
        tick();
        chk("rel_if_ready",  b1.if_ready,  0);
        chk("rel_d_ready",   b1.d_ready,   0);
        chk("rel_grant_d",   grant_d1,     1);
        chk("rel_mem_en",    b1.mem_en,    1);
        drop_reqs();
        repeat (6) tick();

        // Single fetch, WAIT_CYCLES=1
        do_reset();
        b1.if_addr = 32'h4; b1.if_req = 1'b1;
        tick();
        chk("f1_mem_en",   b1.mem_en,   1);
        chk("f1_mem_addr", b1.mem_addr, 32'h4);
        chk("f1_mem_we",   b1.mem_we,   0);
        chk("f1_if_ready", b1.if_ready, 0);
        tick();
        chk("f2_if_ready", b1.if_ready, 1);
        chk("f2_if_rdata", b1.if_rdata, 32'h2008_0005);
        chk("f2_mem_en",   b1.mem_en,   0);
        b1.if_req = 1'b0;
        tick();
        chk("f3_if_ready", b1.if_ready, 0);
        chk("f3_busy",     busy1,       0);

        // Tie after reset: data first, then fetch
        do_reset();
        b1.d_addr = 32'h54; b1.d_we = 1'b0; b1.d_req = 1'b1;
        b1.if_addr = 32'h8; b1.if_req = 1'b1;
        tick();
        chk("t1_grant_d",  grant_d1,    1);
        chk("t1_mem_addr", b1.mem_addr, 32'h54);
        tick();
        chk("t2_d_ready",  b1.d_ready,  1);
        chk("t2_if_ready", b1.if_ready, 0);
        chk("t2_d_rdata",  b1.d_rdata,  32'h1111_2222);
        b1.d_req = 1'b0;
        tick();
        chk("t3_busy",     busy1,       0);
        tick();
        chk("t4_mem_en",   b1.mem_en,   1);
        chk("t4_mem_addr", b1.mem_addr, 32'h8);
        chk("t4_grant_d",  grant_d1,    0);
        tick();
        chk("t5_if_ready", b1.if_ready, 1);
        chk("t5_if_rdata", b1.if_rdata, 32'h8C09_0054);
        chk("t5_d_rdata",  b1.d_rdata,  32'h1111_2222);
        b1.if_req = 1'b0;
        tick();

        // Fairness: both ports request continuously
        do_reset();
        b1.d_addr = 32'h54; b1.d_req = 1'b1;
        b1.if_addr = 32'h4; b1.if_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = 0;
            while (!(b1.if_ready || b1.d_ready) && k < 6) begin
                tick();
                k++;
            end
            chk("fair_ready",   32'(b1.if_ready | b1.d_ready), 1);
            chk("fair_grant",   grant_d1,   (i % 2 == 0) ? 1 : 0);
            chk("fair_d_ready", b1.d_ready, (i % 2 == 0) ? 1 : 0);
            chk("fair_latency", k,          2);
            tick();
        end
        drop_reqs();
        repeat (3) tick();

        // WAIT_CYCLES=3: load, store, load-back
        do_reset();
        b3.d_addr = 32'h10; b3.d_we = 1'b0; b3.d_req = 1'b1;
        tick();
        chk("l1_mem_en",  b3.mem_en,  1);
        tick();
        tick();
        chk("l3_mem_en",  b3.mem_en,  1);
        chk("l3_d_ready", b3.d_ready, 0);
        tick();
        chk("l4_d_ready", b3.d_ready, 1);
        chk("l4_d_rdata", b3.d_rdata, 32'h0000_ABCD);
        chk("l4_busy",    busy3,      1);
        b3.d_req = 1'b0;
        tick();
        chk("l5_busy",    busy3,      0);

        b3.d_addr = 32'h54; b3.d_wdata = 32'h7; b3.d_we = 1'b1; b3.d_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("st_mem_we",    b3.mem_we,    1);
            chk("st_mem_addr",  b3.mem_addr,  32'h54);
            chk("st_mem_wdata", b3.mem_wdata, 32'h7);
            chk("st_d_ready",   b3.d_ready,   0);
        end
        tick();
        chk("st4_d_ready", b3.d_ready, 1);
        chk("st4_mem_we",  b3.mem_we,  0);
        chk("st4_d_rdata", b3.d_rdata, 32'h0000_ABCD);
        b3.d_req = 1'b0; b3.d_we = 1'b0;
        tick();

        b3.d_addr = 32'h54; b3.d_req = 1'b1;
        repeat (4) tick();
        chk("lb_d_ready", b3.d_ready, 1);
        chk("lb_d_rdata", b3.d_rdata, 32'h7);
        b3.d_req = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a fetch
        b3.if_addr = 32'h8; b3.if_req = 1'b1;
        tick();
        tick();
        chk("rm2_mem_en", b3.mem_en, 1);
        reset = 1'b1;
        tick();
        chk("rm3_mem_en",   b3.mem_en,   0);
        chk("rm3_busy",     busy3,       0);
        chk("rm3_if_ready", b3.if_ready, 0);
        chk("rm3_mem_addr", b3.mem_addr, 0);
        reset = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk("rm_if_ready_lo", b3.if_ready, 0);
        end
        tick();
        chk("rm7_if_ready", b3.if_ready, 1);
        chk("rm7_if_rdata", b3.if_rdata, 32'h3C01_DEAD);
        b3.if_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
